encoder_multi: RTL and testbench

Parametrised multi-channel encoder divider: synchronises the conveyor encoder pulse train and derives NUM_CH independent trigger square waves (valve, cameras) from it, each at a programmable division ratio. Adds over the fixed five-channel encoder: a generic channel count, selectable single- or double-edge counting, per-channel idle level, per-channel restart on divider change, an enable gate, explicit rise/fall strobes and a free-running position count. Sits between the encoder input pin and the valve/camera trigger logic; dividers come from AXI-Lite registers.

---
 rtl/encoder_pkg.sv | 11 +
 rtl/encoder_div_channel.sv | 56 +++++
 rtl/encoder_multi.sv | 66 ++++++
 tb/tb_encoder_multi.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared defaults and channel slice helper for the encoder divider
package encoder_pkg;
  localparam int DEFAULT_NUM_CH = 5;
  localparam int DEFAULT_CNT_W  = 32;
  localparam logic [DEFAULT_NUM_CH-1:0] DEFAULT_IDLE_LEVEL = 5'b11110;

  // Base bit of channel ch inside a packed per-channel vector of w-bit fields.
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction
endpackage

// File: rtl/encoder_div_channel.sv
// rtl/encoder_div_channel.sv - one divided trigger channel with restart on divider change
module encoder_div_channel
  import encoder_pkg::*;
#(
  parameter int   CNT_W = DEFAULT_CNT_W,
  parameter logic IDLE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [CNT_W-1:0] divider,
  output logic             out_signal,
  output logic             out_rise,
  output logic             out_fall
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shd;
  logic [CNT_W-1:0] half;
  logic             active;

  assign half   = divider >> 1;
  assign active = (half != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shd        <= '0;
      out_signal <= IDLE;
      out_rise   <= 1'b0;
      out_fall   <= 1'b0;
    end else begin
      out_rise <= 1'b0;
      out_fall <= 1'b0;
      // A new ratio restarts the phase; a coincident tick is deliberately dropped.
      if (divider != shd) begin
        shd        <= divider;
        cnt        <= '0;
        out_signal <= IDLE;
      end else if (!active) begin
        cnt        <= '0;
        out_signal <= IDLE;
      end else if (tick) begin
        if (cnt == half - CNT_W'(1)) begin
          cnt        <= '0;
          out_signal <= ~out_signal;
          out_rise   <= ~out_signal;
          out_fall   <= out_signal;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/encoder_multi.sv
// rtl/encoder_multi.sv - encoder input synchroniser, tick qualification, position count and channel array
module encoder_multi
  import encoder_pkg::*;
#(
  parameter int                NUM_CH      = DEFAULT_NUM_CH,
  parameter int                CNT_W       = DEFAULT_CNT_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] IDLE_LEVEL  = DEFAULT_IDLE_LEVEL
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    in_signal,
  input  logic                    enable,
  input  logic                    edge_mode,
  input  logic [NUM_CH*CNT_W-1:0] divider,
  output logic [NUM_CH-1:0]       out_signal,
  output logic [NUM_CH-1:0]       out_rise,
  output logic [NUM_CH-1:0]       out_fall,
  output logic [CNT_W-1:0]        pulse_count
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   synced;
  logic                   tick;

  assign synced = sync[SYNC_STAGES-1];

  // The synchroniser keeps running while disabled so edges seen during the gate are not replayed.
  always_comb begin
    tick = 1'b0;
    if (enable) begin
      tick = edge_mode ? (synced ^ hist) : (synced & ~hist);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync        <= '0;
      hist        <= 1'b0;
      pulse_count <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_signal};
      hist <= synced;
      if (tick) begin
        pulse_count <= pulse_count + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    encoder_div_channel #(
      .CNT_W (CNT_W),
      .IDLE  (IDLE_LEVEL[i])
    ) u_ch (
      .clk        (sys_clk),
      .rst        (rst),
      .tick       (tick),
      .divider    (divider[ch_lsb(i, CNT_W) +: CNT_W]),
      .out_signal (out_signal[i]),
      .out_rise   (out_rise[i]),
      .out_fall   (out_fall[i])
    );
  end

endmodule

// File: tb/tb_encoder_multi.sv
// tb/tb_encoder_multi.sv - scoreboard bench for encoder_multi
module tb_encoder_multi;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 32;
  localparam int SYNC_STAGES = 2;
  localparam logic [NUM_CH-1:0] IDLE = 5'b11110;

  logic                    sys_clk;
  logic                    rst;
  logic                    in_signal;
  logic                    enable;
  logic                    edge_mode;
  logic [NUM_CH*CNT_W-1:0] divider;
  logic [NUM_CH-1:0]       out_signal;
  logic [NUM_CH-1:0]       out_rise;
  logic [NUM_CH-1:0]       out_fall;
  logic [CNT_W-1:0]        pulse_count;

  logic       s_out;
  logic       s_rise;
  logic       s_fall;
  logic [3:0] s_pc;

  encoder_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(IDLE)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .in_signal(in_signal), .enable(enable),
    .edge_mode(edge_mode), .divider(divider), .out_signal(out_signal),
    .out_rise(out_rise), .out_fall(out_fall), .pulse_count(pulse_count)
  );

  encoder_multi #(
    .NUM_CH(1), .CNT_W(4), .SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)
  ) dut_small (
    .sys_clk(sys_clk), .rst(rst), .in_signal(in_signal), .enable(enable),
    .edge_mode(edge_mode), .divider(4'd0), .out_signal(s_out),
    .out_rise(s_rise), .out_fall(s_fall), .pulse_count(s_pc)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [3:0]  ch;
    logic        rise;
    logic [31:0] pc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_pc   = 0;
  int  half_m[NUM_CH];
  int  base_m[NUM_CH];
  int  tog_m[NUM_CH];

  function automatic logic [NUM_CH-1:0] exp_out();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = IDLE[c] ^ tog_m[c][0];
    return v;
  endfunction

  // Advance the expected tick count by one; rch restarts on this tick and loses it.
  function automatic void model_tick(input int rch);
    ev_t e;
    exp_pc++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (c == rch) begin
        base_m[c] = exp_pc;
        tog_m[c]  = 0;
      end else if (half_m[c] > 0 && ((exp_pc - base_m[c]) % half_m[c]) == 0) begin
        tog_m[c]++;
        e.ch   = 4'(c);
        e.rise = IDLE[c] ^ tog_m[c][0];
        e.pc   = 32'(exp_pc);
        exp_q.push_back(e);
      end
    end
  endfunction

  always @(negedge sys_clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (out_rise[i] || out_fall[i]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected ch=%0d rise=%b fall=%b pc=%0d, required no strobe",
                     i, out_rise[i], out_fall[i], pulse_count);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.ch !== 4'(i) || out_rise[i] !== e.rise || out_fall[i] !== ~e.rise ||
                pulse_count !== e.pc || out_signal[i] !== e.rise) begin
              n_fail++;
              $display("FAIL strobe_event got ch=%0d rise=%b fall=%b out=%b pc=%0d, required ch=%0d rise=%b pc=%0d",
                       i, out_rise[i], out_fall[i], out_signal[i], pulse_count, e.ch, e.rise, e.pc);
            end
          end
        end
      end
    end
  end

  task automatic enc_period();
    in_signal = 1'b1;
    repeat (4) @(posedge sys_clk);
    #2;
    in_signal = 1'b0;
    repeat (4) @(posedge sys_clk);
    #2;
  endtask

  task automatic run_periods(input int n);
    for (int k = 0; k < n; k++) begin
      model_tick(-1);
      if (edge_mode) model_tick(-1);
      enc_period();
    end
  endtask

  task automatic set_div(input int ch, input int v);
    divider[ch*CNT_W +: CNT_W] = CNT_W'(v);
    half_m[ch] = v / 2;
    base_m[ch] = exp_pc;
    tog_m[ch]  = 0;
    repeat (2) @(posedge sys_clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_signal = 1'b0; enable = 1'b1; edge_mode = 1'b0; divider = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      half_m[c] = 0; base_m[c] = 0; tog_m[c] = 0;
    end
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (out_signal !== IDLE || out_rise !== '0 || out_fall !== '0 || pulse_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state got out=%b rise=%b fall=%b pc=%0d, required out=%b rise=0 fall=0 pc=0",
               out_signal, out_rise, out_fall, pulse_count, IDLE);
    end
    @(posedge sys_clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #2;
  endtask

  task automatic check_state(input string name);
    @(negedge sys_clk);
    n_checks++;
    if (pulse_count !== 32'(exp_pc) || out_signal !== exp_out() || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s got pc=%0d out=%b pending=%0d, required pc=%0d out=%b pending=0",
               name, pulse_count, out_signal, exp_q.size(), exp_pc, exp_out());
    end
    @(posedge sys_clk);
    #2;
  endtask

  task automatic test_single_edge();
    edge_mode = 1'b0;
    set_div(0, 4);
    run_periods(10);
    check_state("single_edge");
  endtask

  task automatic test_double_edge();
    edge_mode = 1'b1;
    set_div(1, 4);
    run_periods(4);
    check_state("double_edge");
  endtask

  task automatic test_restart();
    edge_mode = 1'b0;
    set_div(2, 8);
    run_periods(2);
    half_m[2] = 3;
    model_tick(2);
    in_signal = 1'b1;
    repeat (SYNC_STAGES) @(posedge sys_clk);
    #2;
    divider[2*CNT_W +: CNT_W] = 32'd6;
    @(negedge sys_clk);
    n_checks++;
    if (out_signal[2] !== IDLE[2] || out_rise[2] !== 1'b0 || out_fall[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_idle got out=%b rise=%b fall=%b, required out=%b rise=0 fall=0",
               out_signal[2], out_rise[2], out_fall[2], IDLE[2]);
    end
    repeat (4) @(posedge sys_clk);
    #2;
    in_signal = 1'b0;
    repeat (4) @(posedge sys_clk);
    #2;
    run_periods(6);
    check_state("restart_after");
  endtask

  task automatic test_disabled_odd();
    edge_mode = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) set_div(3, 1);
      run_periods(1);
      n_checks++;
      if (out_signal[3] !== 1'b1) begin
        n_fail++;
        $display("FAIL disabled_ch3 tick=%0d got out=%b, required 1", k, out_signal[3]);
      end
    end
    set_div(3, 7);
    run_periods(12);
    check_state("odd_divider");
  endtask

  task automatic test_enable();
    run_periods(1);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) enc_period();
    check_state("enable_frozen");
    enable = 1'b1;
    run_periods(5);
    check_state("enable_resume");
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4 && exp_out()[0] !== 1'b1; k++) run_periods(1);
    @(posedge sys_clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_signal !== IDLE || out_rise !== '0 || out_fall !== '0 || pulse_count !== '0 || s_pc !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset got out=%b rise=%b fall=%b pc=%0d spc=%0d, required out=%b 0 0 0 0",
               out_signal, out_rise, out_fall, pulse_count, s_pc, IDLE);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pre_reset_pending got %0d events, required 0", exp_q.size());
      exp_q.delete();
    end
    exp_pc = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      base_m[c] = 0; tog_m[c] = 0;
    end
    @(posedge sys_clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #2;
    check_state("post_reset_restart");
    edge_mode = 1'b0;
    run_periods(17);
    check_state("post_reset_count");
    n_checks++;
    if (s_pc !== 4'd1) begin
      n_fail++;
      $display("FAIL pc_wrap got %0d, required 1", s_pc);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_double_edge();
    test_restart();
    test_disabled_odd();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
